// File: rtl/fp_multiply.sv
// Sequential IEEE-754 single-precision multiplier: one shift-and-add step per cycle,
// then a single normalisation cycle with truncation and overflow/underflow flags.
module fp_multiply (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        START,
    input  logic [31:0] InputA,
    input  logic [31:0] InputB,
    output logic [31:0] AxB,
    output logic        DONE,
    output logic        BUSY,
    output logic [1:0]  EXCEPTION
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_NORM = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [7:0]  exp_a_q, exp_a_d;
    logic [7:0]  exp_b_q, exp_b_d;
    logic [47:0] mcand_q, mcand_d;
    logic [23:0] mplier_q, mplier_d;
    logic [47:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] axb_q, axb_d;
    logic [1:0]  exc_q, exc_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic signed [9:0] e_sum_s;
    logic signed [9:0] e_norm_s;
    logic [22:0]       mant_s;

    // Exponent and mantissa of the finished product; 10-bit signed so nothing wraps.
    always_comb begin
        e_sum_s = $signed({2'b00, exp_a_q}) + $signed({2'b00, exp_b_q});
        if (acc_q[47]) begin
            e_norm_s = e_sum_s - 10'sd126;
            mant_s   = acc_q[46:24];
        end else begin
            e_norm_s = e_sum_s - 10'sd127;
            mant_s   = acc_q[45:23];
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_a_d  = exp_a_q;
        exp_b_d  = exp_b_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        axb_d    = axb_q;
        exc_d    = exc_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    // Zero and denormal operands bypass the multiplier entirely.
                    if ((InputA[30:23] == 8'd0) || (InputB[30:23] == 8'd0)) begin
                        axb_d   = {InputA[31] ^ InputB[31], 31'd0};
                        exc_d   = 2'b00;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        sign_d   = InputA[31] ^ InputB[31];
                        exp_a_d  = InputA[30:23];
                        exp_b_d  = InputB[30:23];
                        mcand_d  = {24'd0, 1'b1, InputA[22:0]};
                        mplier_d = {1'b1, InputB[22:0]};
                        acc_d    = 48'd0;
                        cnt_d    = 5'd0;
                        state_d  = S_MULT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MULT: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = {mcand_q[46:0], 1'b0};
                mplier_d = {1'b0, mplier_q[23:1]};
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd23) begin
                    state_d = S_NORM;
                end else begin
                    state_d = S_MULT;
                end
            end
            S_NORM: begin
                if ((e_norm_s >= 10'sd255) || (exp_a_q == 8'hFF) || (exp_b_q == 8'hFF)) begin
                    axb_d = {sign_q, 8'hFF, 23'd0};
                    exc_d = 2'b10;
                end else if (e_norm_s <= 10'sd0) begin
                    axb_d = {sign_q, 31'd0};
                    exc_d = 2'b01;
                end else begin
                    axb_d = {sign_q, e_norm_s[7:0], mant_s};
                    exc_d = 2'b00;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            exp_a_q  <= 8'd0;
            exp_b_q  <= 8'd0;
            mcand_q  <= 48'd0;
            mplier_q <= 24'd0;
            acc_q    <= 48'd0;
            cnt_q    <= 5'd0;
            axb_q    <= 32'd0;
            exc_q    <= 2'b00;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_a_q  <= exp_a_d;
            exp_b_q  <= exp_b_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            axb_q    <= axb_d;
            exc_q    <= exc_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign AxB       = axb_q;
    assign EXCEPTION = exc_q;
    assign DONE      = done_q;
    assign BUSY      = busy_q;

endmodule

// File: doc/fp_multiply.md
FP_MULTIPLY -- requirements
Module: fp_multiply

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 CLOCK  input  1  rising-edge clock for all state.
REQ-003 RESET  input  1  asynchronous active-low reset; low forces the reset state immediately.
REQ-004 START  input  1  request pulse; sampled only in IDLE.
REQ-005 InputA  input  32  IEEE-754 single-precision multiplicand, captured on the accepting edge.
REQ-006 InputB  input  32  IEEE-754 single-precision multiplier, captured on the accepting edge.
REQ-007 AxB  output  32  product {sign, exponent[7:0], mantissa[22:0]}, held until the next result is written.
REQ-008 DONE  output  1  one-cycle pulse when AxB and EXCEPTION are valid.
REQ-009 BUSY  output  1  high in every state except IDLE.
REQ-010 EXCEPTION  output  2  00 none, 01 underflow, 10 overflow, 11 unused; held with AxB.

Function
REQ-011 SHALL implement states IDLE, MULT, NORM; encoding is free.
REQ-012 In IDLE with START=0, SHALL hold all outputs and stay in IDLE.
REQ-013 Zero shortcut: in IDLE with START=1 and InputA[30:23]==0 or InputB[30:23]==0, SHALL write AxB={InputA[31]^InputB[31],31'b0}, EXCEPTION=00, DONE=1 on that edge, and stay in IDLE.
REQ-014 Denormal inputs (exponent 0, nonzero fraction) SHALL be treated as zero per REQ-013.
REQ-015 Otherwise, in IDLE with START=1, SHALL capture sign=A[31]^B[31], mA={1,A[22:0]}, mB={1,B[22:0]}, both exponents; clear the 48-bit accumulator and 5-bit counter; go to MULT.
REQ-016 In MULT, SHALL process one multiplier bit per cycle, LSB first, by shift-and-add into the 48-bit product; counter increments each cycle; after the 24th bit, go to NORM.
REQ-017 Product P SHALL equal mA*mB exactly (48 bits, no truncation before NORM).
REQ-018 Normalisation: if P[47]=1, mantissa=P[46:24] and E=expA+expB-126; else mantissa=P[45:23] and E=expA+expB-127.
REQ-019 E SHALL be computed in at least 10-bit signed arithmetic; no wrap-around permitted.
REQ-020 Rounding SHALL be truncation (discarded bits dropped).
REQ-021 If E>=255, or either input exponent is 8'hFF (non-zero-shortcut case), SHALL write AxB={sign,8'hFF,23'b0}, EXCEPTION=10.
REQ-022 Else if E<=0, SHALL write AxB={sign,31'b0}, EXCEPTION=01.
REQ-023 Else SHALL write AxB={sign,E[7:0],mantissa}, EXCEPTION=00.
REQ-024 The NORM edge SHALL write AxB/EXCEPTION, set DONE=1 for exactly one cycle, and return to IDLE.
REQ-025 Latency: START accepted at edge k -> DONE high during the cycle after edge k+25; back-to-back START accepted on edge k+26 or later.
REQ-026 START while BUSY=1 SHALL be ignored; InputA/InputB changes after capture SHALL not affect the result.
REQ-027 DONE SHALL be 0 in every cycle not specified by REQ-013/REQ-024.

Reset
REQ-028 RESET=0 SHALL asynchronously force state IDLE, AxB=0, EXCEPTION=00, DONE=0, BUSY=0, accumulator and counter 0.
REQ-029 Reset during MULT or NORM SHALL abort the operation with no DONE pulse; a START after release starts a fresh operation.

Verification
REQ-030 START, A=0x40000000 (2.0), B=0x40400000 (3.0) -> AxB=0x40C00000, EXCEPTION=00, DONE one cycle, 26 edges after accept.
REQ-031 A=0x3FC00000 (1.5), B=0x3FC00000 (1.5) -> AxB=0x40100000 (P[47]=1 path); A=0xC0000000, B=0x3F000000 -> AxB=0xBF800000.
REQ-032 A=0x00000000, B=0x40400000 -> AxB=0x00000000, EXCEPTION=00, DONE on the edge after START, BUSY never high.
REQ-033 A=0x7F000000, B=0x7F000000 -> AxB=0x7F800000, EXCEPTION=10; A=B=0x00800000 -> AxB=0x00000000, EXCEPTION=01.
REQ-034 Assert RESET=0 at counter=10 of a 2.0*3.0 operation -> outputs zero immediately, no DONE; after release, 1.5*1.5 -> 0x40100000.
REQ-035 Pulse START at every cycle while BUSY=1 with changing inputs -> exactly one DONE per accepted START, result matches captured operands.
